axi_skid_fifo: RTL

AXI_SKID_FIFO -- requirements
Module: axi_skid_fifo

---
 rtl/axi_module_pkg.sv | 15 +
 rtl/axi_fifo_mem.sv | 28 ++
 rtl/axi_skid_fifo.sv | 82 ++++++++
 3 files changed

// File: rtl/axi_module_pkg.sv
// Shared constants and helpers for the AXI stream buffer blocks.
// Holds the default data path sizing and a constant clog2.
package axi_module_pkg;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_DEPTH  = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/axi_fifo_mem.sv
// Register-array storage for the skid FIFO.
// One synchronous write port, one asynchronous read port, no reset.
module axi_fifo_mem
    import axi_module_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              aclk_i,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge aclk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_skid_fifo.sv
// Registered-ready buffer between two valid/ready stream ports.
// Adds INC to each accepted word; ready_o comes straight from a flop.
module axi_skid_fifo
    import axi_module_pkg::*;
#(
    parameter int                DWIDTH   = DEF_DWIDTH,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [DWIDTH-1:0] INC      = 1,
    parameter int                AFULL_TH = DEPTH - 1
) (
    input  logic                       aclk_i,
    input  logic                       areset_i,
    input  logic                       valid_i,
    input  logic [DWIDTH-1:0]          data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [DWIDTH-1:0]          data_o,
    input  logic                       ready_i,
    output logic [clog2(DEPTH+1)-1:0]  count_o,
    output logic                       almost_full_o
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int AW = clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_nxt;
    logic              ready_q;
    logic              valid_q;
    logic              afull_q;
    logic              push;
    logic              pop;
    logic [DWIDTH-1:0] rd_data;

    assign push      = valid_i && ready_q;
    assign pop       = valid_q && ready_i;
    assign count_nxt = count_q + CW'(push) - CW'(pop);

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_nxt;
            ready_q <= count_nxt < DEPTH_C;
            valid_q <= count_nxt != '0;
            afull_q <= count_nxt >= AFULL_C;
        end
    end

    axi_fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .aclk_i (aclk_i),
        .we     (push),
        .waddr  (wptr_q),
        .wdata  (data_i + INC),
        .raddr  (rptr_q),
        .rdata  (rd_data)
    );

    // Mask the unreset array so an empty buffer always shows zero.
    assign data_o        = valid_q ? rd_data : '0;
    assign valid_o       = valid_q;
    assign ready_o       = ready_q;
    assign count_o       = count_q;
    assign almost_full_o = afull_q;

endmodule
